// File: rtl/fifo_512_unpacker.sv
// fifo_512_unpacker: drains wide words from a FIFO read port and serialises
// each into IN_WIDTH/OUT_WIDTH narrow slices on a valid/ready stream.
// A one-word prefetch register hides the FIFO read latency between words.
// Optional build macro: UNPACKER_MSB_FIRST_EN (emit most-significant slice first).
module fifo_512_unpacker #(
   parameter int unsigned IN_WIDTH  = 512,
   parameter int unsigned OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty,
   output logic                 fifo_re,
   input  logic [IN_WIDTH-1:0]  fifo_dout,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
);

   localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

   logic                 pending_q,    pending_d;
   logic                 next_valid_q, next_valid_d;
   logic [IN_WIDTH-1:0]  next_word_q,  next_word_d;
   logic                 cur_valid_q,  cur_valid_d;
   logic [IN_WIDTH-1:0]  cur_word_q,   cur_word_d;
   logic [IDX_W-1:0]     idx_q,        idx_d;
   logic [OUT_WIDTH-1:0] out_data_q,   out_data_d;
   logic                 out_last_q,   out_last_d;
   logic                 busy_q,       busy_d;

   logic                 slice_acc_c;
   logic                 at_last_c;
   logic                 cur_free_c;

   // Pick slice number idx out of a word, honouring the emission order.
   function automatic logic [OUT_WIDTH-1:0] slice_of(input logic [IN_WIDTH-1:0] word,
                                                     input logic [IDX_W-1:0]    idx);
      logic [IDX_W-1:0]    sel;
      logic [IN_WIDTH-1:0] shifted;
`ifdef UNPACKER_MSB_FIRST_EN
      sel = IDX_LAST - idx;
`else
      sel = idx;
`endif
      shifted = word >> (OUT_WIDTH * 32'(sel));
      return shifted[OUT_WIDTH-1:0];
   endfunction

   // Read request: only when nothing is in flight and the prefetch slot is free.
   assign fifo_re = reset && !fifo_empty && !pending_q && !next_valid_q;

   assign slice_acc_c = cur_valid_q && out_ready;
   assign at_last_c   = (idx_q == IDX_LAST);
   assign cur_free_c  = !cur_valid_q || (slice_acc_c && at_last_c);

   // Next-state: slice advance, word reload and capture of the pending read.
   always_comb begin
      pending_d    = fifo_re;
      next_valid_d = next_valid_q;
      next_word_d  = next_word_q;
      cur_valid_d  = cur_valid_q;
      cur_word_d   = cur_word_q;
      idx_d        = idx_q;

      if (cur_free_c) begin
         idx_d = '0;
         if (next_valid_q) begin
            cur_valid_d  = 1'b1;
            cur_word_d   = next_word_q;
            next_valid_d = pending_q;
            if (pending_q) begin
               next_word_d = fifo_dout;
            end
         end else if (pending_q) begin
            cur_valid_d = 1'b1;
            cur_word_d  = fifo_dout;
         end else begin
            cur_valid_d = 1'b0;
         end
      end else begin
         if (slice_acc_c) begin
            idx_d = idx_q + IDX_W'(1);
         end
         if (pending_q) begin
            next_valid_d = 1'b1;
            next_word_d  = fifo_dout;
         end
      end

      out_data_d = cur_valid_d ? slice_of(cur_word_d, idx_d) : '0;
      out_last_d = cur_valid_d && (idx_d == IDX_LAST);
      busy_d     = cur_valid_d || next_valid_d || pending_d;
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q    <= 1'b0;
         next_valid_q <= 1'b0;
         cur_valid_q  <= 1'b0;
         idx_q        <= '0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         pending_q    <= pending_d;
         next_valid_q <= next_valid_d;
         cur_valid_q  <= cur_valid_d;
         idx_q        <= idx_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
      end
   end

   // Word storage; contents are qualified by the valid flags so no reset needed.
   always_ff @(posedge clk) begin
      cur_word_q  <= cur_word_d;
      next_word_q <= next_word_d;
   end

   assign out_valid = cur_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

   // Never read an empty FIFO, and never hold a pending read with a full prefetch slot.
   a_no_underflow: assert property (@(posedge clk) disable iff (!reset) fifo_re |-> !fifo_empty);
   a_no_overfill:  assert property (@(posedge clk) disable iff (!reset) !(pending_q && next_valid_q));

endmodule

// File: tb/tb_fifo_512_unpacker.sv
// Randomised bench for fifo_512_unpacker: a queue-based FIFO model feeds the
// DUT and a slice-level scoreboard predicts every emitted slice.
module tb_fifo_512_unpacker;

   localparam int unsigned IN_W  = 512;
   localparam int unsigned OUT_W = 32;
   localparam int unsigned RATIO = IN_W / OUT_W;

   logic             clk = 1'b0;
   logic             reset;
   logic             fifo_empty;
   logic             fifo_re;
   logic [IN_W-1:0]  fifo_dout;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             busy;

   fifo_512_unpacker #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_re    (fifo_re),
      .fifo_dout  (fifo_dout),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [IN_W-1:0] fifo_q[$];
   logic [OUT_W:0]  exp_q[$];
   int   n_cmp, n_err;
   int   cyc, last_re_cyc;
   int   re_cnt, acc_cnt, valid_cnt, gap_cnt;
   int   rdy_mode, rdy_ph;
   logic started, prev_valid, re_s;

   // Count one comparison and report it when it does not match.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected slice stream of one word: {last flag, data}.
   task automatic expect_word(input logic [IN_W-1:0] w);
      int unsigned sel;
      logic [IN_W-1:0] t;
      for (int k = 0; k < int'(RATIO); k++) begin
`ifdef UNPACKER_MSB_FIRST_EN
         sel = RATIO - 1 - k;
`else
         sel = k;
`endif
         t = w >> (OUT_W * sel);
         exp_q.push_back({k == int'(RATIO) - 1, t[OUT_W-1:0]});
      end
   endtask

   task automatic fifo_push(input logic [IN_W-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   function automatic logic [IN_W-1:0] rand_word();
      logic [IN_W-1:0] w = '0;
      for (int k = 0; k < int'(RATIO); k++) w = (w << OUT_W) | IN_W'($urandom);
      return w;
   endfunction

   task automatic reset_stats();
      re_cnt = 0; acc_cnt = 0; valid_cnt = 0; gap_cnt = 0; started = 1'b0;
   endtask

   // Mid-cycle observation and scoreboard update.
   task automatic check_phase();
      int held;
      @(negedge clk);
      cyc++;
      held = (exp_q.size() + int'(RATIO) - 1) / int'(RATIO);
      if (fifo_re) begin
         check("underflow", 64'(fifo_empty), 64'(0));
         check("re_while_full", 64'(held > 1), 64'(0));
      end
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (out_valid) begin
         if (exp_q.size() == 0) check("spurious_valid", 64'(1), 64'(0));
         else begin
            check("data", 64'(out_data), 64'(exp_q[0][OUT_W-1:0]));
            check("last", 64'(out_last), 64'(exp_q[0][OUT_W]));
         end
         if (!prev_valid) check("latency", 64'(cyc - last_re_cyc), 64'(2));
         started = 1'b1;
         valid_cnt++;
      end else begin
         check("last_idle", 64'(out_last), 64'(0));
         if (started && exp_q.size() != 0) gap_cnt++;
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         acc_cnt++;
      end
      if (fifo_re) begin
         re_cnt++;
         last_re_cyc = cyc;
      end
      re_s       = fifo_re;
      prev_valid = out_valid;
   endtask

   // Just after the edge: FIFO model pops on a read, new ready value is driven.
   task automatic edge_phase();
      logic [IN_W-1:0] w;
      @(posedge clk);
      #1;
      if (re_s && reset && fifo_q.size() != 0) begin
         w = fifo_q.pop_front();
         fifo_dout = w;
         expect_word(w);
      end
      fifo_empty = (fifo_q.size() == 0);
      case (rdy_mode)
         1:       out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
      rdy_ph++;
   endtask

   task automatic cycle();
      check_phase();
      edge_phase();
   endtask

   task automatic drain(input int max, input string tag);
      int i = 0;
      do begin
         cycle();
         i++;
      end while ((exp_q.size() != 0 || fifo_q.size() != 0) && i < max);
      check(tag, 64'(exp_q.size() + fifo_q.size()), 64'(0));
      cycle();
      cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [IN_W-1:0] w;
      logic            flag;
      int              i;
      n_cmp = 0; n_err = 0; cyc = 0; last_re_cyc = -100;
      rdy_mode = 0; rdy_ph = 0; prev_valid = 1'b0; re_s = 1'b0;
      reset = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; out_ready = 1'b1;
      reset_stats();

      // Reset held with a non-empty FIFO: no reads, idle outputs.
      w = '0;
      for (int k = 0; k < int'(RATIO); k++) w = w | (IN_W'(32'hA000_0000 + 32'(k)) << (k * OUT_W));
      fifo_push(w);
      repeat (3) begin
         @(negedge clk);
         check("rst_re", 64'(fifo_re), 64'(0));
         check("rst_valid", 64'(out_valid), 64'(0));
         check("rst_data", 64'(out_data), 64'(0));
         check("rst_last", 64'(out_last), 64'(0));
         check("rst_busy", 64'(busy), 64'(0));
      end
      @(posedge clk);
      #1 reset = 1'b1;

      // Single word with slice k = 0xA000_0000+k; read on the first cycle after release.
      check_phase();
      check("release_re", 64'(re_s), 64'(1));
      edge_phase();
      drain(100, "single_drain");
      check("single_slices", 64'(acc_cnt), 64'(RATIO));
      check("single_reads", 64'(re_cnt), 64'(1));

      // Back-to-back words: continuous valid, one read per word.
      reset_stats();
      for (int n = 0; n < 4; n++) fifo_push(rand_word());
      drain(300, "b2b_drain");
      check("b2b_valid_cycles", 64'(valid_cnt), 64'(4 * RATIO));
      check("b2b_gaps", 64'(gap_cnt), 64'(0));
      check("b2b_reads", 64'(re_cnt), 64'(4));

      // Backpressure 1,0,0,1 across three words.
      reset_stats();
      rdy_mode = 1; rdy_ph = 0;
      for (int n = 0; n < 3; n++) fifo_push(rand_word());
      drain(500, "bp_drain");
      check("bp_slices", 64'(acc_cnt), 64'(3 * RATIO));

      // Empty FIFO: no reads at all.
      rdy_mode = 0;
      reset_stats();
      repeat (10) cycle();
      check("empty_reads", 64'(re_cnt), 64'(0));

      // FIFO becomes non-empty while the last slice of a word is presented.
      fifo_push(rand_word());
      flag = 1'b0;
      i = 0;
      while (!flag && i < 100) begin
         check_phase();
         flag = out_valid && (exp_q.size() == 1) && (fifo_q.size() == 0);
         edge_phase();
         i++;
      end
      check("boundary_reached", 64'(flag), 64'(1));
      fifo_push(rand_word());
      drain(200, "boundary_drain");
      check("boundary_slices", 64'(acc_cnt), 64'(2 * RATIO));

      // Reset mid-operation while slice 7 of word 2 is presented.
      reset_stats();
      for (int n = 0; n < 3; n++) fifo_push(rand_word());
      i = 0;
      do begin
         cycle();
         i++;
      end while (acc_cnt < int'(RATIO) + 7 && i < 200);
      check("midrst_reached", 64'(acc_cnt), 64'(RATIO + 7));
      #2;
      check("midrst_pre_valid", 64'(out_valid), 64'(1));
      reset = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid), 64'(0));
      check("midrst_data", 64'(out_data), 64'(0));
      check("midrst_last", 64'(out_last), 64'(0));
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_re", 64'(fifo_re), 64'(0));
      fifo_q.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      re_s = 1'b0;
      prev_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      reset_stats();
      for (int n = 0; n < 2; n++) fifo_push(rand_word());
      drain(200, "post_rst_drain");
      check("post_rst_slices", 64'(acc_cnt), 64'(2 * RATIO));

      // Random ready with words arriving at random times.
      reset_stats();
      rdy_mode = 2;
      i = 0;
      repeat (300) begin
         if (i < 8 && $urandom_range(0, 7) == 0) begin
            fifo_push(rand_word());
            i++;
         end
         cycle();
      end
      drain(800, "rand_drain");
      check("rand_slices", 64'(acc_cnt), 64'(i * int'(RATIO)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_512_unpacker.md
# fifo_512_unpacker

Downstream drain stage for the 512-bit `simple_fifo_512` buffer. It pops wide words from the FIFO read port (`re`/`dout`/`empty`) and serialises each into `IN_WIDTH/OUT_WIDTH` narrow slices on a valid/ready stream. This lets the narrow datapath consume bulk-buffered data at one slice per cycle. A one-word prefetch register hides the FIFO read latency, so there are no bubbles between words when `RATIO` ≥ 2.

## Interface
Parameters:
- `IN_WIDTH`, default 512: FIFO word width. Must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, default 32: output slice width.
- `RATIO`, default `IN_WIDTH/OUT_WIDTH` (localparam): slices per word.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset asserted).
- `fifo_empty`, in, 1: FIFO `empty`.
- `fifo_re`, out, 1: FIFO `re`. Combinational.
- `fifo_dout`, in, `IN_WIDTH`: FIFO `dout`. Valid the cycle after `fifo_re`=1.
- `out_data`, out, `OUT_WIDTH`: current slice.
- `out_valid`, out, 1: slice is presented.
- `out_ready`, in, 1: consumer accepts the slice.
- `out_last`, out, 1: presented slice is the final slice of its word.
- `busy`, out, 1: any word is held or in flight.

## Operation
- State:
  - `pending`: read issued last cycle.
  - `next_valid` / `next_word`: prefetch register.
  - `cur_valid` / `cur_word` / `idx` (0..`RATIO`-1): word being emitted.
- Read request: `fifo_re = fifo_empty==0 && !pending && !next_valid`. It never depends on `out_ready`.
- Capture, on the cycle with `pending`=1:
  - If `cur` will be free this edge (it is empty, or its last slice is accepted this cycle), load `fifo_dout` straight into `cur`, `idx`←0.
  - Otherwise load it into `next`.
- Slice accept (`out_valid && out_ready`):
  - When `idx` < `RATIO`-1: `idx`++.
  - When `idx` = `RATIO`-1: `cur` reloads from `next` (`idx`←0, `next_valid`←0) if `next_valid`=1. Else it reloads from the capture if `pending`=1. Else `cur_valid`←0.
- Outputs:
  - `out_valid = cur_valid`.
  - `out_data = cur_word[idx*OUT_WIDTH +: OUT_WIDTH]` (LSB-first, unless the macro below is defined).
  - `out_last = cur_valid && idx==RATIO-1`.
- Stall: while `out_ready`=0, `out_data`, `out_last` and `idx` hold stable. No slice is dropped or duplicated.
- `busy = cur_valid || next_valid || pending`.
- Reset (asynchronous, any time, including mid-word):
  - `pending`, `next_valid`, `cur_valid`, `idx`, `out_data`, `out_last` ← 0.
  - `fifo_re` is 0 while `reset`=0.
  - Data in flight is discarded. The FIFO is reset by the same signal.

## Timing
- First-slice latency: `fifo_empty` falls in cycle 0 → `fifo_re`=1 in cycle 0 → capture at the end of cycle 1 → `out_valid`=1 in cycle 2.
- Throughput:
  - `RATIO` ≥ 2: one slice per cycle while `out_ready`=1 and the FIFO is non-empty. `out_valid` has no gap between words.
  - `RATIO` = 1: one slice per 2 cycles (a `pending` cycle alternates with each read).
- At most 2 words are held at any time (`cur` + `next`). `fifo_re` is never issued while both are full or a read is pending.
- Underflow: `fifo_re` is never asserted while `fifo_empty`=1.
- If `fifo_empty` rises in the same cycle as a capture, the captured word is kept (`empty` only gates new reads).

## Configuration
- `UNPACKER_MSB_FIRST_EN`:
  - Defined: slice `idx` is taken from bits `[(RATIO-idx)*OUT_WIDTH-1 -: OUT_WIDTH]`, so the most-significant slice is emitted first.
  - Undefined: LSB-first as above.
- Handshake, timing and `out_last` are identical in both builds.

## Test plan
- Reset: hold `reset`=0 with `fifo_empty`=0 → `fifo_re`=0, `out_valid`=0, `out_data`=0, `busy`=0. Release → `fifo_re`=1 on the first cycle.
- Single word: FIFO holds one word where slice k = 0xA000_0000+k, `out_ready`=1.
  - `out_valid` rises 2 cycles after `fifo_re`.
  - Default build: 16 slices 0xA000_0000..0xA000_000F in order, `out_last` only on 0xA000_000F.
  - With `UNPACKER_MSB_FIRST_EN`: order reversed.
- Back-to-back: 4 words queued, `out_ready`=1 → 64 consecutive `out_valid` cycles with no gap. Exactly 4 `fifo_re` pulses.
- Backpressure: `out_ready` toggled 1,0,0,1 repeating across 3 words.
  - Every slice appears exactly once, in order.
  - `out_data` is stable during stalls.
  - `fifo_re` is never 1 while `next_valid` and `cur_valid` are both set.
- Empty boundary: hold `fifo_empty`=1 throughout → `fifo_re` stays 0. Make the FIFO non-empty mid-emission of the last slice → the next word's first slice follows with the 2-cycle latency.
- Reset mid-operation: assert `reset`=0 at slice 7 of word 2.
  - All outputs are 0 asynchronously (before the next clock edge).
  - After release and new FIFO contents, emission restarts at slice 0 of the new word.
